// File: rtl/axi_ram_store.sv
// Dual-port 128-bit word store behind the AXI4-Lite RAM bridge.
// Port A writes (optionally one 32-bit lane), port B reads; the array is swept to INIT_VALUE after reset.
module axi_ram_store #(
  parameter int unsigned DEPTH        = 8,
  parameter logic [127:0] INIT_VALUE  = '0,
  parameter bit          LANE_WRITE   = 1'b1,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         we,
  input  logic [31:0]  addra,
  input  logic [127:0] wdata,
  input  logic         re,
  input  logic [31:0]  addrb,
  output logic [127:0] rdata,
  output logic         rvalid,
  output logic         init_busy,
  output logic [15:0]  drop_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DW = 128;
  localparam int unsigned LW = 32;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = CW + 1;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] ptr;
  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wa_c;
  logic [AW-1:0] ra_c;
  logic [1:0]    lane_c;
  logic          in_init_c;
  logic [SW-1:0] drop_sum_c;
  logic          unused_addr_bits;

  assign wa_c      = addra[AW+3:4];
  assign ra_c      = addrb[AW+3:4];
  assign lane_c    = addra[3:2];
  assign in_init_c = (state == S_INIT);

  // Address bits above the word index alias; byte/lane offsets below are not used for reads.
  assign unused_addr_bits = ^{addra[31:AW+4], addra[1:0], addrb[31:AW+4], addrb[3:0]};

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_INIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: leave the sweep once the last word has been cleared
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT: if (ptr == AW'(DEPTH - 1)) state_nxt = S_RUN;
      S_RUN:  state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  // Sweep pointer, busy flag and saturating drop counter
  assign drop_sum_c = SW'(drop_cnt) + SW'(we) + SW'(re);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr       <= '0;
      init_busy <= 1'b1;
      drop_cnt  <= '0;
    end else begin
      init_busy <= (state_nxt == S_INIT);
      if (in_init_c) begin
        ptr <= ptr + AW'(1);
        if (we || re) begin
          drop_cnt <= drop_sum_c[CW] ? '1 : drop_sum_c[CW-1:0];
        end
      end
    end
  end

  // Array: not reset, cleared by the sweep; accesses during the sweep are ignored
  always_ff @(posedge clk) begin
    if (in_init_c) begin
      mem[ptr] <= INIT_VALUE;
    end else if (we) begin
      if (LANE_WRITE) begin
        mem[wa_c][{lane_c, 5'd0} +: LW] <= wdata[{lane_c, 5'd0} +: LW];
      end else begin
        mem[wa_c] <= wdata;
      end
    end
  end

  // First read stage: read-first against a same-cycle write; dropped reads return zero
  logic          s1_valid;
  logic [DW-1:0] s1_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= re;
      if (re) begin
        s1_data <= in_init_c ? '0 : mem[ra_c];
      end
    end
  end

  generate
    if (READ_LATENCY >= 2) begin : g_lat2
      logic          s2_valid;
      logic [DW-1:0] s2_data;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign rvalid = s2_valid;
      assign rdata  = s2_data;
    end else begin : g_lat1
      assign rvalid = s1_valid;
      assign rdata  = s1_data;
    end
  endgenerate

endmodule

// File: tb/tb_axi_ram_store.sv
// Randomized self-checking bench for axi_ram_store against a behavioural model of the store.
module tb_axi_ram_store;

  localparam int unsigned DEPTH = 8;
  localparam logic [127:0] INIT = '0;

  logic         clk;
  logic         resetn;
  logic         we;
  logic [31:0]  addra;
  logic [127:0] wdata;
  logic         re;
  logic [31:0]  addrb;
  logic [127:0] rdata;
  logic         rvalid;
  logic         init_busy;
  logic [15:0]  drop_cnt;

  axi_ram_store #(
    .DEPTH(DEPTH), .INIT_VALUE(INIT), .LANE_WRITE(1'b1), .READ_LATENCY(1)
  ) dut (
    .clk(clk), .resetn(resetn), .we(we), .addra(addra), .wdata(wdata),
    .re(re), .addrb(addrb), .rdata(rdata), .rvalid(rvalid),
    .init_busy(init_busy), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: a plain word array plus a count of cycles since reset release
  logic [127:0] m_mem [DEPTH];
  int           m_cycles;
  logic [127:0] e_rdata;
  logic         e_rvalid;
  logic         e_busy;
  int           e_drop;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_cycles = 0;
      e_rdata  = '0;
      e_rvalid = 1'b0;
      e_busy   = 1'b1;
      e_drop   = 0;
      for (int k = 0; k < DEPTH; k++) m_mem[k] = INIT;
    end else begin
      int w;
      int l;
      if (m_cycles < DEPTH) begin
        e_drop = e_drop + int'(we) + int'(re);
        if (e_drop > 65535) e_drop = 65535;
        e_rvalid = re;
        if (re) e_rdata = '0;
        m_cycles++;
      end else begin
        e_rvalid = re;
        if (re) e_rdata = m_mem[int'(addrb[6:4])];
        if (we) begin
          w = int'(addra[6:4]);
          l = int'(addra[3:2]);
          m_mem[w][l*32 +: 32] = wdata[l*32 +: 32];
        end
      end
      e_busy = (m_cycles < DEPTH);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rvalid", 128'(rvalid), 128'(e_rvalid));
      chk("rdata", rdata, e_rdata);
      chk("init_busy", 128'(init_busy), 128'(e_busy));
      chk("drop_cnt", 128'(drop_cnt), 128'(e_drop));
    end
  end

  task automatic step(input logic w, input logic [31:0] aa, input logic [127:0] wd,
                      input logic r, input logic [31:0] ab);
    @(negedge clk);
    #1;
    we = w; addra = aa; wdata = wd; re = r; addrb = ab;
  endtask

  task automatic idle();
    step(1'b0, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1'b0, $urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    resetn = 1'b0; we = 1'b0; re = 1'b0;
    idle();
    chk("reset_drop", 128'(drop_cnt), 128'd0);
    chk("reset_busy", 128'(init_busy), 128'd1);
    chk("reset_rvalid", 128'(rvalid), 128'd0);
    @(negedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Counts cycles from reset release until init_busy falls (bounded)
  task automatic wait_sweep(input string nm);
    int n = 0;
    while (n < 50) begin
      idle();
      n++;
      if (!init_busy) break;
    end
    chk(nm, 128'(n), 128'(DEPTH));
  endtask

  initial begin
    resetn = 1'b0; we = 1'b0; re = 1'b0; addra = '0; addrb = '0; wdata = '0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    resetn = 1'b1;
    wait_sweep("sweep_len0");

    // T1: fill with junk, reset, then every word reads INIT
    for (int k = 0; k < DEPTH; k++)
      for (int l = 0; l < 4; l++)
        step(1'b1, 32'(k*16 + l*4), {4{32'hBAD0_0000 + 32'(k*4 + l)}}, 1'b0, 32'h0);
    do_reset();
    wait_sweep("sweep_len1");
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b0, 32'h0, '0, 1'b1, 32'(k*16));
      idle();
      chk("t1_rvalid", 128'(rvalid), 128'd1);
      chk("t1_word", rdata, INIT);
    end
    chk("t1_drop", 128'(drop_cnt), 128'd0);

    // T2: lane 1 write
    step(1'b1, 32'h14, {4{32'hDEADBEEF}}, 1'b0, 32'h0);
    step(1'b0, 32'h0, '0, 1'b1, 32'h10);
    idle();
    chk("t2_rvalid", 128'(rvalid), 128'd1);
    chk("t2_lane", rdata, 128'h00000000_00000000_DEADBEEF_00000000);
    idle();
    chk("t2_pulse", 128'(rvalid), 128'd0);

    // T3: read-first collision on word 2
    step(1'b1, 32'h20, {4{32'h11112222}}, 1'b0, 32'h0);
    step(1'b1, 32'h20, {4{32'h33334444}}, 1'b1, 32'h20);
    step(1'b0, 32'h0, '0, 1'b1, 32'h20);
    chk("t3_old", rdata, 128'h00000000_00000000_00000000_11112222);
    idle();
    chk("t3_new", rdata, 128'h00000000_00000000_00000000_33334444);

    // T4: aliasing 0x80 -> word 0
    step(1'b1, 32'h80, {4{32'hA5A50F0F}}, 1'b0, 32'h0);
    step(1'b0, 32'h0, '0, 1'b1, 32'h00);
    idle();
    chk("t4_alias", rdata, 128'h00000000_00000000_00000000_A5A50F0F);

    // T6: lane 3 readback at 0x0C
    step(1'b1, 32'h0C, {4{32'h12345678}}, 1'b0, 32'h0);
    step(1'b0, 32'h0, '0, 1'b1, 32'h0C);
    idle();
    chk("t6_lane3", rdata, 128'h12345678_00000000_00000000_A5A50F0F);
    chk("t6_word", 128'(rdata[127:96]), 128'h12345678);

    // T5: drops during sweep, then reset mid-sweep
    do_reset();
    step(1'b1, 32'h30, {4{32'hFFFFFFFF}}, 1'b0, 32'h0);
    step(1'b0, 32'h0, '0, 1'b1, 32'h30);
    idle();
    chk("t5_drop", 128'(drop_cnt), 128'd2);
    chk("t5_rvalid", 128'(rvalid), 128'd1);
    chk("t5_rdata", rdata, 128'd0);
    do_reset();
    wait_sweep("sweep_len2");
    chk("t5_drop_clr", 128'(drop_cnt), 128'd0);
    step(1'b0, 32'h0, '0, 1'b1, 32'h30);
    idle();
    chk("t5_unchanged", rdata, INIT);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk);
        #1;
        resetn = 1'b0; we = 1'b0; re = 1'b0;
        repeat ($urandom_range(1, 3)) idle();
        @(negedge clk);
        #1;
        resetn = 1'b1;
      end else begin
        step(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom},
             1'($urandom_range(0, 1)), $urandom);
      end
    end
    idle();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
